// File: rtl/matrix_pkg.sv
// Shared types and defaults for the RGB LED matrix scan controller.
// State encoding plus default panel geometry and on-time counter width.
package matrix_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        BLANK = 3'd2,
        LATCH = 3'd3,
        SHOW  = 3'd4
    } state_t;

    localparam int COLS_DEF = 64;
    localparam int ROWS_DEF = 16;
    localparam int ON_W     = 8;

endpackage

// File: rtl/matrix_oe_timer.sv
// Loadable down-counter timing the SHOW window; a load of zero reports done at once
// so the row is shown dark for a single cycle instead of underflowing.
module matrix_oe_timer
    import matrix_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [ON_W-1:0] value,
    output logic            active,
    output logic            done
);

    logic [ON_W-1:0] cnt_q;
    logic [ON_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the SHOW cycles remaining including the current one.
    assign active = (cnt_q != '0);
    assign done   = (cnt_q[ON_W-1:1] == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row scan sequencer for a dual-half RGB LED panel: SHIFT, BLANK, LATCH, SHOW per row,
// producing col/row indices, sclk, lat, oe_n and frame_start, all registered.
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int COL_W = 6,
    parameter int ROW_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       on_time,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             sclk,
    output logic             lat,
    output logic             oe_n,
    output logic             frame_start,
    output logic             busy
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    state_t            state_q, state_d;
    logic              ph_q, ph_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ON_W-1:0]   on_reg_q, on_reg_d;
    logic              sclk_q, sclk_d;
    logic              lat_q, lat_d;
    logic              oe_n_q, oe_n_d;
    logic              frame_start_q, frame_start_d;
    logic              busy_q, busy_d;

    logic              timer_load;
    logic              timer_active;
    logic              timer_done;

    matrix_oe_timer u_oe_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .value  (on_reg_q),
        .active (timer_active),
        .done   (timer_done)
    );

    // Every output is computed one cycle ahead so it lines up with the state it belongs to.
    always_comb begin
        state_d       = state_q;
        ph_d          = ph_q;
        col_d         = col_q;
        row_d         = row_q;
        on_reg_d      = on_reg_q;
        sclk_d        = 1'b0;
        lat_d         = 1'b0;
        oe_n_d        = 1'b1;
        frame_start_d = 1'b0;
        timer_load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d       = SHIFT;
                    ph_d          = 1'b0;
                    col_d         = '0;
                    row_d         = '0;
                    on_reg_d      = on_time;
                    frame_start_d = 1'b1;
                end
            end
            SHIFT: begin
                if (!ph_q) begin
                    ph_d   = 1'b1;
                    sclk_d = 1'b1;
                end else begin
                    ph_d = 1'b0;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = BLANK;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            BLANK: begin
                state_d = LATCH;
                lat_d   = 1'b1;
            end
            LATCH: begin
                state_d    = SHOW;
                timer_load = 1'b1;
                oe_n_d     = (on_reg_q == '0);
            end
            SHOW: begin
                oe_n_d = !(timer_active && !timer_done);
                if (timer_done) begin
                    ph_d = 1'b0;
                    if (row_q != ROW_LAST) begin
                        row_d   = row_q + 1'b1;
                        state_d = SHIFT;
                    end else begin
                        // en is only honoured here, at the frame boundary.
                        row_d = '0;
                        if (en) begin
                            state_d       = SHIFT;
                            on_reg_d      = on_time;
                            frame_start_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ph_q          <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            on_reg_q      <= '0;
            sclk_q        <= 1'b0;
            lat_q         <= 1'b0;
            oe_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ph_q          <= ph_d;
            col_q         <= col_d;
            row_q         <= row_d;
            on_reg_q      <= on_reg_d;
            sclk_q        <= sclk_d;
            lat_q         <= lat_d;
            oe_n_q        <= oe_n_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign col         = col_q;
    assign row         = row_q;
    assign sclk        = sclk_q;
    assign lat         = lat_q;
    assign oe_n        = oe_n_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule
